axi_lite_sram_bridge: RTL and testbench
=======================================

// Module: axi_lite_sram_bridge
// PURPOSE
//  AXI4-Lite slave that maps single-beat reads and writes onto an
//  asynchronous SRAM. The SRAM has CE/OE/WE controls and a shared
//  bidirectional data bus.
//  - Sits between an AXI-Lite master (CPU/DMA fabric) and the SRAM pins.
//  - Only one transaction, read or write, is ever outstanding.
// PARAMETERS
//  AXI_ADDR_WIDTH  20  word address width; also the SRAM address width
//  AXI_DATA_WIDTH  16  data width; also the SRAM data width
// PORTS
//  axi_clk       in   1   sole clock
//  axi_resetn    in   1   reset, synchronous, active-low
//  axi_awaddr    in   AW  write address
//  axi_awvalid   in   1   write address valid
//  axi_awready   out  1   write address ready
//  axi_wdata     in   DW  write data
//  axi_wstrb     in   1   write strobe; ignored, every write is full-width
//  axi_wvalid    in   1   write data valid
//  axi_wready    out  1   write data ready
//  axi_bresp     out  2   write response: 2'b00 while bvalid, else 2'bxx
//  axi_bvalid    out  1   write response valid
//  axi_bready    in   1   write response ready
//  axi_araddr    in   AW  read address
//  axi_arvalid   in   1   read address valid
//  axi_arready   out  1   read address ready
//  axi_rdata     out  DW  read data; SRAM word while rvalid, else 'x
//  axi_rresp     out  2   read response: 2'b00 while rvalid, else 2'bxx
//  axi_rvalid    out  1   read data valid
//  axi_rready    in   1   read data ready
//  sram_io_addr  out  AW  SRAM address
//  sram_io_data  inout DW SRAM data; driven only while writing, else 'z
//  sram_io_we_n  out  1   SRAM write enable, active-low
//  sram_io_oe_n  out  1   SRAM output enable, active-low
//  sram_io_ce_n  out  1   SRAM chip enable, active-low
// BEHAVIOUR
//  - Reset:
//    - awready, wready, arready, bvalid, rvalid = 0.
//    - ce_n = we_n = oe_n = 1; sram_io_addr = 0; sram_io_data = 'z.
//    - FSM returns to IDLE; any in-flight transaction is abandoned.
//  - FSM states: IDLE, W_ACC, W_SRAM, W_RESP, R_ACC, R_SRAM, R_RESP.
//  - IDLE transitions:
//    - awvalid && wvalid -> W_ACC. Writes have priority over reads.
//    - else arvalid -> R_ACC.
//    - awvalid without wvalid, or the reverse, is never accepted;
//      awready stays 0.
//  - W_ACC:
//    - awready = wready = 1 for exactly one cycle.
//    - awaddr/wdata are latched on that edge; next state W_SRAM.
//  - W_SRAM, one cycle:
//    - ce_n = 0, we_n = 0, oe_n = 1.
//    - sram_io_addr = latched address; sram_io_data = latched data.
//    - Next state W_RESP.
//  - W_RESP:
//    - ce_n = we_n = 1; data bus released ('z).
//    - bvalid = 1, bresp = 00.
//    - On the edge with bvalid && bready: bvalid -> 0, next state IDLE.
//  - R_ACC:
//    - arready = 1 for exactly one cycle; araddr latched.
//    - Next state R_SRAM.
//  - R_SRAM, one cycle:
//    - ce_n = 0, oe_n = 0, we_n = 1; addr = latched address.
//    - sram_io_data is sampled into rdata at the end of the cycle.
//    - Next state R_RESP.
//  - R_RESP:
//    - rvalid = 1, rresp = 00; rdata holds stable.
//    - On the edge with rvalid && rready: rvalid -> 0, next state IDLE.
//  - Blocking: while a write or read response is pending (W_RESP/R_RESP),
//    awready, wready and arready all stay 0, whatever valids are present.
//  - Latency:
//    - arvalid seen in IDLE -> rvalid rises 3 edges later.
//    - Write: bvalid rises 3 edges after IDLE sees awvalid && wvalid.
//  - Back-to-back: with bready held at 1 and valids held high, a new write
//    is accepted every 4 cycles (3 to bvalid, 1 to clear it).
// TESTING
//  - awvalid=1 alone, awaddr=0x0A0, wvalid=0, held 10 cycles
//    -> awready stays 0 every cycle.
//  - Write 0x0C0/0x20 with bready=0, then offer 0x0C1/0x21
//    -> awready 0 for 10 cycles; bvalid=1, bresp=00.
//    - Then raise bready -> next negedge bvalid=0, bresp=xx.
//  - Write 0x0E0=0x40, then read 0x0E0 -> rvalid=1, rdata=0x40, rresp=00.
//  - Interleaved: write 0xE0..0xE2, then alternate reads and writes
//    to 0xE3..0xE5 -> every read returns 0x50+offset.
//  - Read 0xF0 (holds 0x60) with rready=0:
//    - one cycle later rvalid=0, rdata=xx.
//    - Then rvalid=1, rdata=0x60.
//    - New ar and aw offered -> both stay unready for 10 cycles.
//    - After rready -> write 0xF1=0x61 lands; read 0xF1 returns 0x61.
//  - Fast writes 0xD0..0xD2 with valids held high and bready=1
//    -> each accepted; SRAM afterwards holds 0x30..0x32.

Source files
------------

// File: rtl/axi_lite_sram_bridge.sv
// AXI4-Lite slave bridging single-beat reads/writes onto an asynchronous SRAM.
// One transaction in flight at a time; SRAM pins and AXI handshakes are registered.
module axi_lite_sram_bridge #(
  parameter int AXI_ADDR_WIDTH = 20,
  parameter int AXI_DATA_WIDTH = 16
) (
  input  logic                      axi_clk,
  input  logic                      axi_resetn,
  input  logic [AXI_ADDR_WIDTH-1:0] axi_awaddr,
  input  logic                      axi_awvalid,
  output logic                      axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0] axi_wdata,
  input  logic                      axi_wstrb,
  input  logic                      axi_wvalid,
  output logic                      axi_wready,
  output logic [1:0]                axi_bresp,
  output logic                      axi_bvalid,
  input  logic                      axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0] axi_araddr,
  input  logic                      axi_arvalid,
  output logic                      axi_arready,
  output logic [AXI_DATA_WIDTH-1:0] axi_rdata,
  output logic [1:0]                axi_rresp,
  output logic                      axi_rvalid,
  input  logic                      axi_rready,
  output logic [AXI_ADDR_WIDTH-1:0] sram_io_addr,
  inout  wire  [AXI_DATA_WIDTH-1:0] sram_io_data,
  output logic                      sram_io_we_n,
  output logic                      sram_io_oe_n,
  output logic                      sram_io_ce_n
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    W_ACC  = 3'd1,
    W_SRAM = 3'd2,
    W_RESP = 3'd3,
    R_ACC  = 3'd4,
    R_SRAM = 3'd5,
    R_RESP = 3'd6
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic                      r_awready;
  logic                      r_arready;
  logic                      r_bvalid;
  logic                      r_rvalid;
  logic                      r_ce_n;
  logic                      r_we_n;
  logic                      r_oe_n;
  logic                      r_drive;
  logic [AXI_ADDR_WIDTH-1:0] r_addr;
  logic [AXI_DATA_WIDTH-1:0] r_wdata;
  logic [AXI_DATA_WIDTH-1:0] r_rdata;

  logic w_awready_next;
  logic w_arready_next;
  logic w_bvalid_next;
  logic w_rvalid_next;
  logic w_ce_n_next;
  logic w_we_n_next;
  logic w_oe_n_next;
  logic w_drive_next;

  // Strobes carry no information here: every write is full-width.
  logic w_unused;
  assign w_unused = axi_wstrb;

  always_ff @(posedge axi_clk) begin
    if (!axi_resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_awready_next = 1'b0;
    w_arready_next = 1'b0;
    w_bvalid_next  = 1'b0;
    w_rvalid_next  = 1'b0;
    w_ce_n_next    = 1'b1;
    w_we_n_next    = 1'b1;
    w_oe_n_next    = 1'b1;
    w_drive_next   = 1'b0;

    case (r_state)
      IDLE: begin
        if (axi_awvalid && axi_wvalid) begin
          w_state_next = W_ACC;
        end else if (axi_arvalid) begin
          w_state_next = R_ACC;
        end
      end
      W_ACC:  w_state_next = W_SRAM;
      W_SRAM: w_state_next = W_RESP;
      W_RESP: if (axi_bready) w_state_next = IDLE;
      R_ACC:  w_state_next = R_SRAM;
      R_SRAM: w_state_next = R_RESP;
      R_RESP: if (axi_rready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase

    // Outputs are decoded from the upcoming state so the registered pins
    // line up exactly with the state they belong to, free of decode glitches.
    w_awready_next = (w_state_next == W_ACC);
    w_arready_next = (w_state_next == R_ACC);
    w_bvalid_next  = (w_state_next == W_RESP);
    w_rvalid_next  = (w_state_next == R_RESP);
    w_ce_n_next    = !((w_state_next == W_SRAM) || (w_state_next == R_SRAM));
    w_we_n_next    = !(w_state_next == W_SRAM);
    w_oe_n_next    = !(w_state_next == R_SRAM);
    w_drive_next   = (w_state_next == W_SRAM);
  end

  always_ff @(posedge axi_clk) begin
    if (!axi_resetn) begin
      r_awready <= 1'b0;
      r_arready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_rvalid  <= 1'b0;
      r_ce_n    <= 1'b1;
      r_we_n    <= 1'b1;
      r_oe_n    <= 1'b1;
      r_drive   <= 1'b0;
    end else begin
      r_awready <= w_awready_next;
      r_arready <= w_arready_next;
      r_bvalid  <= w_bvalid_next;
      r_rvalid  <= w_rvalid_next;
      r_ce_n    <= w_ce_n_next;
      r_we_n    <= w_we_n_next;
      r_oe_n    <= w_oe_n_next;
      r_drive   <= w_drive_next;
    end
  end

  always_ff @(posedge axi_clk) begin
    if (!axi_resetn) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (r_state == W_ACC) begin
        r_addr  <= axi_awaddr;
        r_wdata <= axi_wdata;
      end
      if (r_state == R_ACC) begin
        r_addr <= axi_araddr;
      end
      // The SRAM has had the whole R_SRAM cycle for its access time.
      if (r_state == R_SRAM) begin
        r_rdata <= sram_io_data;
      end
    end
  end

  assign axi_awready  = r_awready;
  assign axi_wready   = r_awready;
  assign axi_arready  = r_arready;
  assign axi_bvalid   = r_bvalid;
  assign axi_rvalid   = r_rvalid;
  assign axi_bresp    = r_bvalid ? 2'b00 : 2'bxx;
  assign axi_rresp    = r_rvalid ? 2'b00 : 2'bxx;
  assign axi_rdata    = r_rvalid ? r_rdata : {AXI_DATA_WIDTH{1'bx}};

  assign sram_io_addr = r_addr;
  assign sram_io_ce_n = r_ce_n;
  assign sram_io_we_n = r_we_n;
  assign sram_io_oe_n = r_oe_n;
  assign sram_io_data = r_drive ? r_wdata : {AXI_DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_axi_lite_sram_bridge.sv
// Bench for axi_lite_sram_bridge: directed scenarios plus random traffic,
// checked against an address->data reference map and a behavioural SRAM.
module tb_axi_lite_sram_bridge;

  localparam int AW = 20;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [AW-1:0] awaddr = '0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [DW-1:0] wdata = '0;
  logic          wstrb = 1'b0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready = 1'b0;
  logic [AW-1:0] araddr = '0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready = 1'b0;
  logic [AW-1:0] sram_addr;
  wire  [DW-1:0] sram_data;
  logic          sram_we_n;
  logic          sram_oe_n;
  logic          sram_ce_n;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [DW-1:0] sram_mem [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Asynchronous SRAM: drives the bus while reading, captures mid-pulse on write.
  assign sram_data = (!sram_ce_n && !sram_oe_n && sram_we_n) ? sram_mem[sram_addr] : {DW{1'bz}};
  always @(negedge clk) begin
    if (!sram_ce_n && !sram_we_n) sram_mem[sram_addr] <= sram_data;
  end

  axi_lite_sram_bridge #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) dut (
    .axi_clk(clk), .axi_resetn(resetn),
    .axi_awaddr(awaddr), .axi_awvalid(awvalid), .axi_awready(awready),
    .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wvalid(wvalid), .axi_wready(wready),
    .axi_bresp(bresp), .axi_bvalid(bvalid), .axi_bready(bready),
    .axi_araddr(araddr), .axi_arvalid(arvalid), .axi_arready(arready),
    .axi_rdata(rdata), .axi_rresp(rresp), .axi_rvalid(rvalid), .axi_rready(rready),
    .sram_io_addr(sram_addr), .sram_io_data(sram_data),
    .sram_io_we_n(sram_we_n), .sram_io_oe_n(sram_oe_n), .sram_io_ce_n(sram_ce_n)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Completes a write whose valids are already presented.
  task automatic wr_finish(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int bdelay, input bit chk_lat);
    int lat;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!awready && lat < 40);
    check("wr_awready", awready, 1);
    check("wr_wready", wready, 1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    ref_mem[a] = d;
    if (chk_lat) begin
      @(negedge clk); lat++;
      check("wr_sram_ce_n", sram_ce_n, 0);
      check("wr_sram_we_n", sram_we_n, 0);
      check("wr_sram_oe_n", sram_oe_n, 1);
      check("wr_sram_addr", sram_addr, a);
      check("wr_sram_data", sram_data, d);
    end
    while (!bvalid && lat < 40) begin @(negedge clk); lat++; end
    if (chk_lat) check("wr_latency", lat, 3);
    check("wr_bvalid", bvalid, 1);
    check("wr_bresp", bresp, 0);
    check("wr_resp_ce_n", sram_ce_n, 1);
    check("wr_resp_we_n", sram_we_n, 1);
    for (int i = 0; i < bdelay; i++) begin
      @(negedge clk);
      check("wr_bhold", bvalid, 1);
      check("wr_blk_arready", arready, 0);
    end
    bready = 1'b1;
    @(negedge clk);
    check("wr_bclear", bvalid, 0);
    bready = 1'b0;
    check("wr_sram_mem", sram_mem[a], d);
    $display("WRITE addr=%05h data=%04h bdelay=%0d", a, d, bdelay);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int bdelay);
    @(negedge clk);
    awaddr  = a;
    wdata   = d;
    wstrb   = 1'($urandom);
    awvalid = 1'b1;
    wvalid  = 1'b1;
    wr_finish(a, d, bdelay, 1'b1);
  endtask

  // Completes a read whose arvalid is already presented.
  task automatic rd_finish(input logic [AW-1:0] a, input int rdelay, input bit chk_lat);
    int lat;
    logic [DW-1:0] exp;
    exp = ref_mem.exists(a) ? ref_mem[a] : '0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!arready && lat < 40);
    check("rd_arready", arready, 1);
    check("rd_no_awready", awready, 0);
    @(posedge clk); #1;
    arvalid = 1'b0;
    if (chk_lat) begin
      @(negedge clk); lat++;
      check("rd_sram_ce_n", sram_ce_n, 0);
      check("rd_sram_oe_n", sram_oe_n, 0);
      check("rd_sram_we_n", sram_we_n, 1);
      check("rd_sram_addr", sram_addr, a);
    end
    while (!rvalid && lat < 40) begin @(negedge clk); lat++; end
    if (chk_lat) check("rd_latency", lat, 3);
    check("rd_rvalid", rvalid, 1);
    check("rd_rdata", rdata, exp);
    check("rd_rresp", rresp, 0);
    check("rd_resp_oe_n", sram_oe_n, 1);
    for (int i = 0; i < rdelay; i++) begin
      @(negedge clk);
      check("rd_rhold", rvalid, 1);
      check("rd_rdata_stable", rdata, exp);
    end
    rready = 1'b1;
    @(negedge clk);
    check("rd_rclear", rvalid, 0);
    rready = 1'b0;
    $display("READ  addr=%05h data=%04h exp=%04h rdelay=%0d", a, rdata, exp, rdelay);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int rdelay);
    @(negedge clk);
    araddr  = a;
    arvalid = 1'b1;
    rd_finish(a, rdelay, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acc_cyc [3];
    logic [AW-1:0] a;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", awready, 0);
    check("rst_wready", wready, 0);
    check("rst_arready", arready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_ce_n", sram_ce_n, 1);
    check("rst_we_n", sram_we_n, 1);
    check("rst_oe_n", sram_oe_n, 1);
    check("rst_addr", sram_addr, 0);
    resetn = 1'b1;

    // Lone awvalid, then lone wvalid: never accepted
    @(negedge clk);
    awaddr = 20'h000A0; awvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("aw_alone_awready", awready, 0);
      check("aw_alone_ce_n", sram_ce_n, 1);
    end
    awvalid = 1'b0; wdata = 16'h1234; wvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("w_alone_wready", wready, 0);
    end
    wvalid = 1'b0;

    // Response pending blocks a new write
    @(negedge clk);
    awaddr = 20'h000C0; wdata = 16'h0020; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!awready && n < 20);
    check("blk_first_awready", awready, 1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    ref_mem[20'h000C0] = 16'h0020;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    check("blk_bvalid", bvalid, 1);
    check("blk_bresp", bresp, 0);
    awaddr = 20'h000C1; wdata = 16'h0021; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("blk_awready", awready, 0);
      check("blk_wready", wready, 0);
      check("blk_bhold", bvalid, 1);
      check("blk_bresp_hold", bresp, 0);
    end
    bready = 1'b1;
    @(negedge clk);
    check("blk_bclear", bvalid, 0);
    wr_finish(20'h000C1, 16'h0021, 0, 1'b0);
    check("blk_mem_c0", sram_mem[20'h000C0], 16'h0020);
    check("blk_mem_c1", sram_mem[20'h000C1], 16'h0021);

    // Write then read back
    do_write(20'h000E0, 16'h0040, 0);
    do_read(20'h000E0, 0);

    // Interleaved reads and writes
    for (int k = 0; k < 3; k++) do_write(20'h000E0 + 20'(k), 16'h0050 + 16'(k), 0);
    for (int k = 3; k < 6; k++) begin
      do_write(20'h000E0 + 20'(k), 16'h0050 + 16'(k), 1);
      do_read(20'h000E0 + 20'(k), 0);
    end
    for (int k = 0; k < 6; k++) do_read(20'h000E0 + 20'(k), 0);

    // Read held by rready=0 blocks both channels; write wins afterwards
    do_write(20'h000F0, 16'h0060, 0);
    @(negedge clk);
    araddr = 20'h000F0; arvalid = 1'b1; rready = 1'b0;
    @(negedge clk);
    check("hold_rvalid_early", rvalid, 0);
    check("hold_arready", arready, 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    check("hold_rvalid", rvalid, 1);
    check("hold_rdata", rdata, 16'h0060);
    araddr = 20'h000F1; arvalid = 1'b1;
    awaddr = 20'h000F1; wdata = 16'h0061; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_blk_awready", awready, 0);
      check("hold_blk_arready", arready, 0);
      check("hold_rdata_stable", rdata, 16'h0060);
    end
    rready = 1'b1;
    @(negedge clk);
    check("hold_rclear", rvalid, 0);
    rready = 1'b0;
    wr_finish(20'h000F1, 16'h0061, 0, 1'b0);
    rd_finish(20'h000F1, 0, 1'b0);

    // Back-to-back writes with valids held high
    bready = 1'b1;
    @(negedge clk);
    awaddr = 20'h000D0; wdata = 16'h0030; awvalid = 1'b1; wvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!awready && n < 20) begin @(negedge clk); n++; end
      check("fast_awready", awready, 1);
      acc_cyc[k] = cyc;
      @(posedge clk); #1;
      ref_mem[20'h000D0 + 20'(k)] = 16'h0030 + 16'(k);
      if (k < 2) begin
        awaddr = 20'h000D0 + 20'(k + 1);
        wdata  = 16'h0030 + 16'(k + 1);
      end else begin
        awvalid = 1'b0; wvalid = 1'b0;
      end
      if (k > 0) check("fast_spacing", 32'(acc_cyc[k] - acc_cyc[k-1]), 4);
      $display("FASTWR addr=%05h accepted at cycle %0d", 20'h000D0 + 20'(k), acc_cyc[k]);
    end
    repeat (6) @(negedge clk);
    check("fast_bdone", bvalid, 0);
    bready = 1'b0;
    for (int k = 0; k < 3; k++) check("fast_mem", sram_mem[20'h000D0 + 20'(k)], 16'h0030 + 16'(k));

    // Reset while a write is on the SRAM pins
    @(negedge clk);
    awaddr = 20'h00200; wdata = 16'hBEEF; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!awready && n < 20);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    check("mid_ce_active", sram_ce_n, 0);
    resetn = 1'b0;
    @(negedge clk);
    check("mid_rst_ce_n", sram_ce_n, 1);
    check("mid_rst_we_n", sram_we_n, 1);
    check("mid_rst_addr", sram_addr, 0);
    check("mid_rst_bvalid", bvalid, 0);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    check("mid_no_bvalid", bvalid, 0);
    do_read(20'h000D1, 0);

    // Random traffic
    for (int t = 0; t < 40; t++) begin
      a = 20'h00300 + 20'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1 && ref_mem.exists(a))
        do_read(a, $urandom_range(0, 3));
      else
        do_write(a, 16'($urandom), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
